// File: rtl/scan_mux_pkg.sv
// Shared definitions for scan_mux: mode encoding and parameter legality rule.
package scan_mux_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    function automatic bit params_legal(input int unsigned width,
                                        input int unsigned channels,
                                        input int unsigned dwell);
        return (width >= 1) && (channels >= 2) && (dwell >= 1);
    endfunction

endpackage

// File: rtl/scan_mux_seq.sv
// Round-robin scan sequencer: pointer/dwell counter, scan-entry detection, wrap.
module scan_mux_seq
    import scan_mux_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DWELL    = 4,
    parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             dis,
    output logic [SEL_W-1:0] ptr,
    output logic             wrap_next,
    output logic             advance
);

    localparam int unsigned      CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] LAST_PTR = SEL_W'(CHANNELS - 1);

    logic [SEL_W-1:0] ptr_q;
    logic [CNT_W-1:0] cnt_q;
    mode_e            mode_q;
    logic             fresh_q;
    logic             scan;
    logic             first;
    logic [SEL_W-1:0] eff_ptr;
    logic [CNT_W-1:0] eff_cnt;

    // fresh_q covers a scan entry taken while disabled: history has already
    // moved to scan, but the first enabled cycle must still start at channel 0.
    always_comb begin
        scan      = (mode == MODE_SCAN);
        first     = scan && ((mode_q == MODE_MANUAL) || fresh_q);
        eff_ptr   = first ? '0 : ptr_q;
        eff_cnt   = first ? '0 : cnt_q;
        advance   = scan && !dis && (eff_cnt == LAST_CNT);
        wrap_next = scan && !dis && !first && (ptr_q == '0) && (cnt_q == '0);
        ptr       = eff_ptr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_MANUAL;
            fresh_q <= 1'b1;
        end else begin
            mode_q <= mode_e'(mode);
            if (!scan) begin
                ptr_q   <= '0;
                cnt_q   <= '0;
                fresh_q <= 1'b1;
            end else if (!dis) begin
                fresh_q <= 1'b0;
                if (advance) begin
                    cnt_q <= '0;
                    ptr_q <= (eff_ptr == LAST_PTR) ? '0 : eff_ptr + SEL_W'(1);
                end else begin
                    cnt_q <= eff_cnt + CNT_W'(1);
                    ptr_q <= eff_ptr;
                end
            end
        end
    end

endmodule

// File: rtl/scan_mux.sv
// Registered N-channel W-bit multiplexer with disable, manual select and timed round-robin scan.
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DWELL    = 4,
    localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] D,
    input  logic [SEL_W-1:0]          S,
    input  logic                      E,
    input  logic                      MODE,
    output logic [WIDTH-1:0]          Y,
    output logic [SEL_W-1:0]          CH,
    output logic                      V,
    output logic                      WRAP
);

    if (!params_legal(WIDTH, CHANNELS, DWELL)) begin : g_bad_params
        $error("scan_mux: illegal parameters (need WIDTH>=1, CHANNELS>=2, DWELL>=1)");
    end

    logic [SEL_W-1:0] ptr;
    logic             wrap_next;
    logic             advance;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] sel_data;
    logic             sel_hit;

    scan_mux_seq #(
        .CHANNELS (CHANNELS),
        .DWELL    (DWELL),
        .SEL_W    (SEL_W)
    ) u_seq (
        .clk       (clk),
        .rst       (rst),
        .mode      (MODE),
        .dis       (E),
        .ptr       (ptr),
        .wrap_next (wrap_next),
        .advance   (advance)
    );

    // sel_hit stays low for select codes beyond the last channel.
    always_comb begin
        sel      = (MODE == MODE_SCAN) ? ptr : S;
        sel_data = '0;
        sel_hit  = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_data = D[i*WIDTH +: WIDTH];
                sel_hit  = 1'b1;
            end
        end
    end

    always_comb begin
        if (advance) assert (MODE == MODE_SCAN && !E);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Y    <= '0;
            CH   <= '0;
            V    <= 1'b0;
            WRAP <= 1'b0;
        end else if (E) begin
            Y    <= '0;
            V    <= 1'b0;
            WRAP <= 1'b0;
        end else begin
            Y    <= sel_hit ? sel_data : '0;
            CH   <= sel;
            V    <= sel_hit;
            WRAP <= wrap_next;
        end
    end

endmodule

// File: doc/scan_mux.md
# scan_mux

Parametrised, registered N-channel, W-bit multiplexer with an active-high disable and two modes: manual select and automatic round-robin scan with a programmable dwell time. It generalises the team's four-bit, two-input enable-gated multiplexer and adds a registered output, a channel-tag output, a valid strobe and a wrap pulse. It sits between sampled parallel sources (switch banks, counters, sensor latches) and a single shared display or serial path.

## Interface
- WIDTH, 4, bits per channel (≥1)
- CHANNELS, 4, number of input channels (≥2)
- DWELL, 4, cycles each channel is held in scan mode (≥1)
- SEL_W, $clog2(CHANNELS), derived select width; not to be overridden
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- D  in  CHANNELS*WIDTH  flattened inputs; channel i occupies D[i*WIDTH +: WIDTH]
- S  in  SEL_W  manual channel select; ignored in scan mode
- E  in  1  disable, active-high; E=1 forces output to zero (same polarity as the existing mux)
- MODE  in  1  0 = manual, 1 = scan
- Y  out  WIDTH  registered selected data
- CH  out  SEL_W  registered index of channel currently on Y
- V  out  1  high when Y holds a valid sample
- WRAP  out  1  one-cycle pulse when scan returns to channel 0

## Operation
- Reset (rst=1 at edge): Y=0, CH=0, V=0, WRAP=0, scan pointer ptr=0, dwell counter cnt=0, mode history register=0. rst has priority over all other inputs.
- Disabled (E=1): Y<=0, V<=0, WRAP<=0, CH holds, ptr and cnt freeze. Scan resumes from the frozen point when E returns to 0.
- Manual (MODE=0, E=0): Y<=D[S], CH<=S, V<=1, WRAP<=0. If S≥CHANNELS (non-power-of-2 CHANNELS), then Y<=0, V<=0, CH<=S.
- Scan (MODE=1, E=0): Y<=D[ptr], CH<=ptr, V<=1. cnt increments every cycle. When cnt==DWELL-1, cnt<=0 and ptr<=ptr+1, with CHANNELS-1 wrapping to 0.
- WRAP<=1 in the same edge that loads CH=0 after CH=CHANNELS-1 in scan mode. It is not asserted on the first scan entry.
- Scan entry: the cycle MODE is sampled 1 after being 0, ptr and cnt are treated as 0. Channel 0 is output that edge and gets a full DWELL cycles.
- Scan exit: manual behaviour applies on the first cycle MODE=0. ptr and cnt are cleared.
- D is sampled every enabled cycle. Input changes mid-dwell appear on Y one cycle later.
- Simultaneous MODE 0→1 with E=1: the entry is recorded (history updates). The first enabled cycle starts at channel 0.

## Timing
- Latency 1 cycle from D/S/ptr to Y/CH/V. No combinational input-to-output path.
- Scan period is CHANNELS*DWELL cycles. Each CH value is held exactly DWELL consecutive enabled cycles.
- DWELL=1: CH advances every cycle, and WRAP pulses every CHANNELS cycles.
- V is 0 on the first cycle after reset release. It becomes 1 on the first enabled edge.

## Structure
- scan_mux_pkg holds MODE_MANUAL=1'b0, MODE_SCAN=1'b1, and the parameter legality checks (CHANNELS≥2, DWELL≥1, WIDTH≥1) as elaboration-time asserts.
- Sub-module scan_mux_seq holds the ptr/cnt sequencer, entry detection and wrap generation. Its outputs are ptr, wrap_next and advance.
- The top level holds the data select, the disable gating and the output registers.

## Test plan
All scenarios use WIDTH=4, CHANNELS=4, DWELL=2, with D = {ch3=4'hD, ch2=4'hC, ch1=4'hB, ch0=4'hA}.
- Reset: hold rst=1 for 2 cycles with arbitrary inputs → Y=0, CH=0, V=0, WRAP=0. Release with MODE=0, S=2, E=0 → next edge Y=4'hC, CH=2, V=1.
- Manual select: S=0,1,2,3 on consecutive cycles → Y=A,B,C,D one cycle delayed, V=1 throughout.
- Disable: E=1 in manual mode with S=1 → next edge Y=0, V=0, CH unchanged. E=0 → Y=4'hB.
- Scan sequence: MODE 0→1 with E=0 → CH = 0,0,1,1,2,2,3,3,0,… and Y follows A,A,B,B,C,C,D,D,A. WRAP=1 only on the edge CH goes 3→0.
- Freeze mid-scan: E=1 for 3 cycles while CH=1 on its first dwell cycle → Y=0, V=0, CH=1. On resume, CH=1 for exactly one more cycle, then 2.
- Reset mid-scan: rst=1 while CH=2 → all outputs 0. Release with MODE=1 held → scan restarts at channel 0 with a full dwell of 2 and no WRAP pulse.
